// File: rtl/display_spi_rx_pkg.sv
// Shared SSD1306 opcode values, synchronizer bundle layout and the argument-count helper
// used by the display_spi receive path.
package display_spi_rx_pkg;

   localparam logic [7:0] CMD_SET_MEM_MODE  = 8'h20;
   localparam logic [7:0] CMD_SET_COL_ADDR  = 8'h21;
   localparam logic [7:0] CMD_SET_PAGE_ADDR = 8'h22;
   localparam logic [7:0] CMD_SET_CONTRAST  = 8'h81;
   localparam logic [7:0] CMD_CHARGE_PUMP   = 8'h8D;
   localparam logic [7:0] CMD_NORMAL        = 8'hA6;
   localparam logic [7:0] CMD_INVERT        = 8'hA7;
   localparam logic [7:0] CMD_SET_MUX       = 8'hA8;
   localparam logic [7:0] CMD_DISPLAY_OFF   = 8'hAE;
   localparam logic [7:0] CMD_DISPLAY_ON    = 8'hAF;
   localparam logic [7:0] CMD_DISP_OFFSET   = 8'hD3;
   localparam logic [7:0] CMD_CLK_DIV       = 8'hD5;
   localparam logic [7:0] CMD_PRECHARGE     = 8'hD9;
   localparam logic [7:0] CMD_COM_PINS      = 8'hDA;
   localparam logic [7:0] CMD_VCOMH         = 8'hDB;

   // Bit positions of the SPI pins inside one synchronizer stage.
   localparam int SYNC_W   = 5;
   localparam int SYNC_CLK = 0;
   localparam int SYNC_DIN = 1;
   localparam int SYNC_CS  = 2;
   localparam int SYNC_DC  = 3;
   localparam int SYNC_RST = 4;
   localparam logic [SYNC_W-1:0] SYNC_IDLE = 5'b10100;

   function automatic logic [1:0] ssd1306_cmd_args(input logic [7:0] op);
      case (op)
         CMD_SET_MEM_MODE, CMD_SET_CONTRAST, CMD_CHARGE_PUMP, CMD_SET_MUX,
         CMD_DISP_OFFSET, CMD_CLK_DIV, CMD_PRECHARGE, CMD_COM_PINS,
         CMD_VCOMH:                            ssd1306_cmd_args = 2'd1;
         CMD_SET_COL_ADDR, CMD_SET_PAGE_ADDR:  ssd1306_cmd_args = 2'd2;
         default:                              ssd1306_cmd_args = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/display_spi_deser.sv
// SPI front end: pin synchronizers, spi_clk rising-edge detect and MSB-first byte assembly.
// Emits one registered byte strobe per 8 bits and flags partial bytes cut off by cs.
module display_spi_deser
   import display_spi_rx_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       spi_clk,
   input  logic       spi_din,
   input  logic       spi_cs,
   input  logic       spi_dc,
   input  logic       spi_rst,
   output logic       byte_valid,
   output logic [7:0] rx_byte,
   output logic       byte_dc,
   output logic       frame_err,
   output logic       disp_rst_n
);

   logic [SYNC_W-1:0] sync_q [SYNC_STAGES];
   logic [SYNC_W-1:0] pins_s;
   logic              clk_q;
   logic [2:0]        bit_cnt;
   logic [6:0]        shift_q;
   logic              rise;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_IDLE;
      end else begin
         sync_q[0] <= {spi_rst, spi_dc, spi_cs, spi_din, spi_clk};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign pins_s     = sync_q[SYNC_STAGES-1];
   assign disp_rst_n = pins_s[SYNC_RST];
   assign rise       = pins_s[SYNC_CLK] & ~clk_q & ~pins_s[SYNC_CS];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_q      <= 1'b0;
         bit_cnt    <= 3'd0;
         shift_q    <= 7'd0;
         byte_valid <= 1'b0;
         rx_byte    <= 8'd0;
         byte_dc    <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         clk_q      <= pins_s[SYNC_CLK];
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (!pins_s[SYNC_RST]) begin
            bit_cnt <= 3'd0;
         end else if (pins_s[SYNC_CS]) begin
            // Deselect mid-byte throws the partial byte away.
            if (bit_cnt != 3'd0) frame_err <= 1'b1;
            bit_cnt <= 3'd0;
         end else if (rise) begin
            shift_q <= {shift_q[5:0], pins_s[SYNC_DIN]};
            if (bit_cnt == 3'd7) begin
               byte_valid <= 1'b1;
               rx_byte    <= {shift_q, pins_s[SYNC_DIN]};
               byte_dc    <= pins_s[SYNC_DC];
               bit_cnt    <= 3'd0;
            end else begin
               bit_cnt <= bit_cnt + 3'd1;
            end
         end
      end
   end

endmodule

// File: rtl/display_spi_rx.sv
// SSD1306 command/data decoder for the display_spi link: tracks display flags and the
// horizontal-addressing window, and writes data bytes into an external page frame buffer.
module display_spi_rx
   import display_spi_rx_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int COLUMNS     = 128,
   parameter int PAGES       = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       spi_clk,
   input  logic                       spi_din,
   input  logic                       spi_cs,
   input  logic                       spi_dc,
   input  logic                       spi_rst,
   output logic                       fb_we,
   output logic [$clog2(PAGES)-1:0]   fb_page,
   output logic [$clog2(COLUMNS)-1:0] fb_column,
   output logic [7:0]                 fb_data,
   output logic                       cmd_valid,
   output logic [7:0]                 cmd_byte,
   output logic                       display_on,
   output logic                       inverted,
   output logic [7:0]                 contrast,
   output logic                       frame_err,
   output logic                       proto_err
);

   localparam int CW = $clog2(COLUMNS);
   localparam int PW = $clog2(PAGES);
   localparam logic [CW-1:0] COL_LAST  = CW'(COLUMNS - 1);
   localparam logic [PW-1:0] PAGE_LAST = PW'(PAGES - 1);

   typedef enum logic [1:0] {IDLE, ARG1, ARG2} dec_state_t;

   logic       byte_valid, byte_dc, disp_rst_n;
   logic [7:0] rx_byte;

   dec_state_t    state_q, state_d;
   logic [7:0]    opcode_q, opcode_d;
   logic [CW-1:0] arg1_q, arg1_d;
   logic [CW-1:0] col_start_q, col_start_d, col_end_q, col_end_d, col_ptr_q, col_ptr_d, wr_col_q, wr_col_d;
   logic [PW-1:0] page_start_q, page_start_d, page_end_q, page_end_d, page_ptr_q, page_ptr_d, wr_page_q, wr_page_d;
   logic          fb_we_d, cmd_valid_d, display_on_d, inverted_d, proto_err_d;
   logic [7:0]    fb_data_d, cmd_byte_d, contrast_d;

   display_spi_deser #(.SYNC_STAGES(SYNC_STAGES)) u_deser (
      .clk        (clk),
      .reset      (reset),
      .spi_clk    (spi_clk),
      .spi_din    (spi_din),
      .spi_cs     (spi_cs),
      .spi_dc     (spi_dc),
      .spi_rst    (spi_rst),
      .byte_valid (byte_valid),
      .rx_byte    (rx_byte),
      .byte_dc    (byte_dc),
      .frame_err  (frame_err),
      .disp_rst_n (disp_rst_n)
   );

   assign fb_page   = fb_we ? wr_page_q : page_ptr_q;
   assign fb_column = fb_we ? wr_col_q  : col_ptr_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      opcode_d     = opcode_q;
      arg1_d       = arg1_q;
      col_start_d  = col_start_q;
      col_end_d    = col_end_q;
      col_ptr_d    = col_ptr_q;
      page_start_d = page_start_q;
      page_end_d   = page_end_q;
      page_ptr_d   = page_ptr_q;
      wr_col_d     = wr_col_q;
      wr_page_d    = wr_page_q;
      fb_we_d      = 1'b0;
      fb_data_d    = fb_data;
      cmd_valid_d  = 1'b0;
      cmd_byte_d   = cmd_byte;
      display_on_d = display_on;
      inverted_d   = inverted;
      contrast_d   = contrast;
      proto_err_d  = 1'b0;
      if (!disp_rst_n) begin
         state_d      = IDLE;
         opcode_d     = 8'd0;
         arg1_d       = '0;
         col_start_d  = '0;
         col_end_d    = COL_LAST;
         col_ptr_d    = '0;
         page_start_d = '0;
         page_end_d   = PAGE_LAST;
         page_ptr_d   = '0;
         wr_col_d     = '0;
         wr_page_d    = '0;
         fb_data_d    = 8'd0;
         cmd_byte_d   = 8'd0;
         display_on_d = 1'b0;
         inverted_d   = 1'b0;
         contrast_d   = 8'h7F;
      end else if (byte_valid && byte_dc) begin
         // A data byte always lands in the buffer; a pending command is simply dropped.
         proto_err_d = (state_q != IDLE);
         state_d     = IDLE;
         fb_we_d     = 1'b1;
         fb_data_d   = rx_byte;
         wr_col_d    = col_ptr_q;
         wr_page_d   = page_ptr_q;
         if (col_ptr_q == col_end_q) begin
            col_ptr_d  = col_start_q;
            page_ptr_d = (page_ptr_q == page_end_q) ? page_start_q : page_ptr_q + 1'b1;
         end else begin
            col_ptr_d = col_ptr_q + 1'b1;
         end
      end else if (byte_valid) begin
         cmd_valid_d = 1'b1;
         cmd_byte_d  = rx_byte;
         case (state_q)
            IDLE: begin
               opcode_d = rx_byte;
               case (rx_byte)
                  CMD_DISPLAY_OFF: display_on_d = 1'b0;
                  CMD_DISPLAY_ON:  display_on_d = 1'b1;
                  CMD_NORMAL:      inverted_d   = 1'b0;
                  CMD_INVERT:      inverted_d   = 1'b1;
                  default: ;
               endcase
               if (ssd1306_cmd_args(rx_byte) != 2'd0) state_d = ARG1;
            end
            ARG1: begin
               // First window argument is staged so an aborted command leaves the window intact.
               arg1_d = rx_byte[CW-1:0];
               if (opcode_q == CMD_SET_CONTRAST) contrast_d = rx_byte;
               state_d = (ssd1306_cmd_args(opcode_q) == 2'd2) ? ARG2 : IDLE;
            end
            ARG2: begin
               if (opcode_q == CMD_SET_COL_ADDR) begin
                  col_start_d = arg1_q;
                  col_ptr_d   = arg1_q;
                  col_end_d   = rx_byte[CW-1:0];
               end else if (opcode_q == CMD_SET_PAGE_ADDR) begin
                  page_start_d = arg1_q[PW-1:0];
                  page_ptr_d   = arg1_q[PW-1:0];
                  page_end_d   = rx_byte[PW-1:0];
               end
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         opcode_q     <= 8'd0;
         arg1_q       <= '0;
         col_start_q  <= '0;
         col_end_q    <= COL_LAST;
         col_ptr_q    <= '0;
         page_start_q <= '0;
         page_end_q   <= PAGE_LAST;
         page_ptr_q   <= '0;
         wr_col_q     <= '0;
         wr_page_q    <= '0;
         fb_we        <= 1'b0;
         fb_data      <= 8'd0;
         cmd_valid    <= 1'b0;
         cmd_byte     <= 8'd0;
         display_on   <= 1'b0;
         inverted     <= 1'b0;
         contrast     <= 8'h7F;
         proto_err    <= 1'b0;
      end else begin
         opcode_q     <= opcode_d;
         arg1_q       <= arg1_d;
         col_start_q  <= col_start_d;
         col_end_q    <= col_end_d;
         col_ptr_q    <= col_ptr_d;
         page_start_q <= page_start_d;
         page_end_q   <= page_end_d;
         page_ptr_q   <= page_ptr_d;
         wr_col_q     <= wr_col_d;
         wr_page_q    <= wr_page_d;
         fb_we        <= fb_we_d;
         fb_data      <= fb_data_d;
         cmd_valid    <= cmd_valid_d;
         cmd_byte     <= cmd_byte_d;
         display_on   <= display_on_d;
         inverted     <= inverted_d;
         contrast     <= contrast_d;
         proto_err    <= proto_err_d;
      end
   end

endmodule

// File: tb/tb_display_spi_rx.sv
// Self-checking bench for display_spi_rx: drives SPI bytes, scoreboards frame-buffer
// writes and command strobes, and checks flags, windows and error pulses.
module tb_display_spi_rx;

   localparam int SYNC_STAGES = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       spi_clk = 1'b0, spi_din = 1'b0, spi_cs = 1'b1, spi_dc = 1'b0, spi_rst = 1'b1;
   logic       fb_we, cmd_valid, display_on, inverted, frame_err, proto_err;
   logic [2:0] fb_page;
   logic [6:0] fb_column;
   logic [7:0] fb_data, cmd_byte, contrast;

   display_spi_rx #(.SYNC_STAGES(SYNC_STAGES), .COLUMNS(128), .PAGES(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .spi_clk    (spi_clk),
      .spi_din    (spi_din),
      .spi_cs     (spi_cs),
      .spi_dc     (spi_dc),
      .spi_rst    (spi_rst),
      .fb_we      (fb_we),
      .fb_page    (fb_page),
      .fb_column  (fb_column),
      .fb_data    (fb_data),
      .cmd_valid  (cmd_valid),
      .cmd_byte   (cmd_byte),
      .display_on (display_on),
      .inverted   (inverted),
      .contrast   (contrast),
      .frame_err  (frame_err),
      .proto_err  (proto_err)
   );

   // Clock / reset
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // Scoreboard
   int          n_cmp = 0, n_bad = 0, n_frame = 0, n_proto = 0;
   longint      t8 = 0, t_strobe = 0;
   logic [17:0] exp_fb_q[$];
   logic [7:0]  exp_cmd_q[$];
   logic [17:0] e_fb;
   logic [7:0]  e_cmd;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (fb_we === 1'b1) begin
         t_strobe = $time;
         if (exp_fb_q.size() == 0) check("fb_we_unexpected", 32'd1, 32'd0);
         else begin
            e_fb = exp_fb_q.pop_front();
            check("fb_write", {14'd0, fb_page, fb_column, fb_data}, {14'd0, e_fb});
         end
      end
      if (cmd_valid === 1'b1) begin
         t_strobe = $time;
         if (exp_cmd_q.size() == 0) check("cmd_valid_unexpected", 32'd1, 32'd0);
         else begin
            e_cmd = exp_cmd_q.pop_front();
            check("cmd_byte", {24'd0, cmd_byte}, {24'd0, e_cmd});
         end
      end
      if (frame_err === 1'b1) n_frame++;
      if (proto_err === 1'b1) n_proto++;
   end

   // Drivers: SPI edges are placed on clk falling edges, half period = 2 clk cycles
   task automatic spi_wait(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bits(input logic dc, input logic [7:0] val, input int nbits);
      spi_cs = 1'b0;
      spi_dc = dc;
      for (int i = 7; i > 7 - nbits; i--) begin
         spi_din = val[i];
         spi_wait(2);
         spi_clk = 1'b1;
         if (i == 0) t8 = $time;
         spi_wait(2);
         spi_clk = 1'b0;
      end
   endtask

   task automatic send_cmd(input logic [7:0] val);
      exp_cmd_q.push_back(val);
      send_bits(1'b0, val, 8);
   endtask

   task automatic send_data(input logic [7:0] val, input logic [2:0] page, input logic [6:0] col);
      exp_fb_q.push_back({page, col, val});
      send_bits(1'b1, val, 8);
   endtask

   task automatic check_flags(input string name, input logic on, input logic inv, input logic [7:0] con);
      check({name, "_display_on"}, {31'd0, display_on}, {31'd0, on});
      check({name, "_inverted"}, {31'd0, inverted}, {31'd0, inv});
      check({name, "_contrast"}, {24'd0, contrast}, {24'd0, con});
   endtask

   typedef struct {
      logic [7:0] b;
      logic       on;
      logic       inv;
      logic [7:0] con;
   } flag_vec_t;

   flag_vec_t  tbl [10];
   logic [7:0] init_seq [25];
   logic [2:0] win_page [7];
   logic [6:0] win_col [7];
   int         nf, np;

   initial begin
      tbl[0] = '{8'hAE, 1'b0, 1'b0, 8'h70};
      tbl[1] = '{8'hAF, 1'b1, 1'b0, 8'h70};
      tbl[2] = '{8'hA7, 1'b1, 1'b1, 8'h70};
      tbl[3] = '{8'h81, 1'b1, 1'b1, 8'h70};
      tbl[4] = '{8'h33, 1'b1, 1'b1, 8'h33};
      tbl[5] = '{8'hA6, 1'b1, 1'b0, 8'h33};
      tbl[6] = '{8'hE3, 1'b1, 1'b0, 8'h33};
      tbl[7] = '{8'h81, 1'b1, 1'b0, 8'h33};
      tbl[8] = '{8'h7F, 1'b1, 1'b0, 8'h7F};
      tbl[9] = '{8'hAE, 1'b0, 1'b0, 8'h7F};
      init_seq = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
                   8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'h70, 8'hD9, 8'hF1,
                   8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
      win_page = '{3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd6};
      win_col  = '{7'd10, 7'd11, 7'd12, 7'd10, 7'd11, 7'd12, 7'd10};

      spi_wait(3);
      reset = 1'b0;
      spi_wait(4);

      // Reset state
      check("rst_strobes", {28'd0, fb_we, cmd_valid, frame_err, proto_err}, 32'd0);
      check("rst_addr", {22'd0, fb_page, fb_column}, 32'd0);
      check("rst_data", {16'd0, fb_data, cmd_byte}, 32'd0);
      check_flags("rst", 1'b0, 1'b0, 8'h7F);

      // Init sequence from display_spi
      for (int i = 0; i < 25; i++) send_cmd(init_seq[i]);
      spi_wait(10);
      check_flags("init", 1'b1, 1'b0, 8'h70);
      check("init_errors", n_frame + n_proto, 0);
      check("init_cmd_pending", exp_cmd_q.size(), 0);
      check("cmd_latency", int'(t_strobe - t8), (SYNC_STAGES + 2) * 10);

      // Flag commands, table-driven
      for (int i = 0; i < 10; i++) begin
         send_cmd(tbl[i].b);
         spi_wait(8);
         check_flags($sformatf("tbl%0d", i), tbl[i].on, tbl[i].inv, tbl[i].con);
      end

      // Full window, 1024 bytes
      send_cmd(8'h21); send_cmd(8'd0); send_cmd(8'd127);
      send_cmd(8'h22); send_cmd(8'd0); send_cmd(8'd7);
      for (int k = 0; k < 1024; k++) send_data(8'(k), 3'(k / 128), 7'(k % 128));
      spi_wait(10);
      check("data_latency", int'(t_strobe - t8), (SYNC_STAGES + 2) * 10);
      check("full_wrap_ptr", {22'd0, fb_page, fb_column}, 32'd0);
      check("full_fb_pending", exp_fb_q.size(), 0);

      // Sub-window wrap
      send_cmd(8'h21); send_cmd(8'd10); send_cmd(8'd12);
      send_cmd(8'h22); send_cmd(8'd6); send_cmd(8'd7);
      for (int i = 0; i < 7; i++) send_data(8'hA0 + 8'(i), win_page[i], win_col[i]);
      spi_wait(10);
      check("win_ptr", {22'd0, fb_page, fb_column}, {22'd0, 3'd6, 7'd11});

      // Partial byte cut by cs
      nf = n_frame;
      send_bits(1'b0, 8'hAE, 5);
      spi_wait(2);
      spi_cs = 1'b1;
      spi_wait(6);
      send_cmd(8'hAF);
      spi_wait(10);
      check("frame_err_count", n_frame - nf, 1);
      check("frame_display_on", {31'd0, display_on}, 32'd1);

      // spi_rst restores defaults
      send_cmd(8'h81); send_cmd(8'h22); send_cmd(8'hA7);
      spi_wait(10);
      check_flags("pre_spirst", 1'b1, 1'b1, 8'h22);
      spi_rst = 1'b0;
      spi_wait(6);
      check_flags("spirst_low", 1'b0, 1'b0, 8'h7F);
      check("spirst_ptr", {22'd0, fb_page, fb_column}, 32'd0);
      spi_rst = 1'b1;
      spi_wait(6);
      check_flags("spirst_high", 1'b0, 1'b0, 8'h7F);

      // Data during pending argument
      np = n_proto;
      send_cmd(8'h81);
      send_data(8'h55, 3'd0, 7'd0);
      spi_wait(10);
      check("proto_err_count", n_proto - np, 1);
      check("proto_contrast", {24'd0, contrast}, 32'h7F);
      send_cmd(8'hAF);
      spi_wait(10);
      check("proto_back_idle", {31'd0, display_on}, 32'd1);

      // Async reset mid-byte
      send_cmd(8'h21); send_cmd(8'd10); send_cmd(8'd12);
      send_cmd(8'h81); send_cmd(8'h44);
      spi_wait(10);
      send_bits(1'b0, 8'hA7, 4);
      reset = 1'b1;
      spi_wait(3);
      check_flags("arst", 1'b0, 1'b0, 8'h7F);
      check("arst_ptr", {22'd0, fb_page, fb_column}, 32'd0);
      reset = 1'b0;
      spi_cs = 1'b1;
      spi_wait(6);
      nf = n_frame;
      send_cmd(8'hA7);
      spi_wait(10);
      check_flags("post_arst", 1'b0, 1'b1, 8'h7F);
      check("post_arst_frame_err", n_frame - nf, 0);

      check("end_cmd_pending", exp_cmd_q.size(), 0);
      check("end_fb_pending", exp_fb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/display_spi_rx.md
Name: display_spi_rx

Overview:
- Receive-side model of the 4-wire SSD1306 SPI link driven by display_spi: deserializes spi_din/spi_clk/spi_cs/spi_dc/spi_rst and decodes the command/data stream.
- Writes data bytes into an external 128x8-page frame buffer through a write port, using horizontal addressing.
- Use cases: loopback verification of display/display_spi, and an on-FPGA display mirror feeding a second output.

Parameters:
SYNC_STAGES, 2, flip-flop stages on each SPI input before edge detection (minimum 2).
COLUMNS, 128, column count; column pointer width 7.
PAGES, 8, page count; page pointer width 3.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
spi_clk  in  1  SPI clock from master, idle low
spi_din  in  1  serial data, MSB first, sampled on spi_clk rising edge
spi_cs  in  1  chip select, active low
spi_dc  in  1  0 = command byte, 1 = data byte
spi_rst  in  1  display reset, active low
fb_we  out  1  one-cycle frame-buffer write strobe
fb_page  out  3  write page address
fb_column  out  7  write column address
fb_data  out  8  write data, bit0 = top row of page
cmd_valid  out  1  one-cycle strobe per received command byte (opcode or argument)
cmd_byte  out  8  the command byte, valid with cmd_valid
display_on  out  1  set by 0xAF, cleared by 0xAE
inverted  out  1  set by 0xA7, cleared by 0xA6
contrast  out  8  last 0x81 argument
frame_err  out  1  one-cycle pulse: cs rose with 1..7 bits collected
proto_err  out  1  one-cycle pulse: data byte arrived while command arguments were pending

Behaviour:
- Reset: all strobes 0, fb_page/fb_column/fb_data 0, cmd_byte 0, display_on 0, inverted 0, contrast 0x7F.
- Reset values: column window 0..127, page window 0..7, pointers 0/0, args_left 0, bit count 0.
- Input conditioning: every SPI input passes through SYNC_STAGES flops. Rising edge = synced spi_clk 0->1 with synced cs low.
- Deserializer: shift din in MSB first on each rising edge. On the 8th bit, emit byte plus the dc value sampled with the 8th bit, then clear the count.
- Synced cs high clears the bit count. If the count was 1..7, pulse frame_err and discard the partial byte. Multiple bytes per cs-low window are allowed.
- Latency: fb_we or cmd_valid asserts exactly SYNC_STAGES+2 clk cycles after the 8th spi_clk rising edge at the pins.
- Synced spi_rst low: return all decoder state, outputs and pointers to reset values and ignore SPI traffic. Decoding resumes the cycle after synced spi_rst returns high.
- Decoder state: IDLE, ARG1, ARG2.
  - IDLE, command byte: latch opcode.
  - Opcodes taking 1 argument go to ARG1: 0x20, 0x81, 0x8D, 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB.
  - Opcodes taking 2 arguments go to ARG1 then ARG2: 0x21, 0x22.
  - 0xAE, 0xAF, 0xA6, 0xA7 update their flags. All other opcodes are no-ops and stay in IDLE.
- Arguments:
  - 0x21: arg1[6:0] sets col_start and the column pointer; arg2[6:0] sets col_end.
  - 0x22: arg1[2:0] sets page_start and the page pointer; arg2[2:0] sets page_end.
  - 0x81: arg sets contrast.
  - 0x20 and the other 1-argument opcodes: argument consumed and ignored; only horizontal mode is implemented.
- Data byte in IDLE: write fb_data at the current pointers for one cycle, then advance:
  - Column != col_end: column +1.
  - Column == col_end: column = col_start; page = page_start if page == page_end, else page +1.
- Data byte in ARG1/ARG2: pulse proto_err, abort the pending command (window unchanged), go to IDLE, and write the byte normally.
- fb_page/fb_column hold the write address during fb_we and otherwise show the current pointer.
- col_end < col_start is not clamped: the column increments and wraps modulo 128 until it equals col_end.
- cmd_valid pulses for every command byte, including arguments, in the cycle its effect is applied.
- Asynchronous reset mid-byte: the partial byte is lost and no strobe is emitted.

Decomposition:
- Opcode values come from the shared display_commands.v defines; add SSD1306_CMD_ARGS(opcode) there as a function returning 0/1/2.
- The decoder state encoding is a localparam inside display_spi_rx.
- Sub-module display_spi_deser holds the synchronizers, edge detect and bit counter. It outputs byte_valid, byte, byte_dc and frame_err.

Test Plan:
- display_spi sends the 25-byte init sequence -> 25 cmd_valid pulses; display_on=1, contrast=0x70, inverted=0, no fb_we, no errors.
- Commands 0x21,0,127,0x22,0,7, then 1024 data bytes of value (i mod 256) -> fb_we 1024 times.
  - Byte k lands at page k/128, column k%128; the pointer returns to 0/0.
- Window 0x21,10,12 / 0x22,6,7, then 7 data bytes -> addresses (6,10),(6,11),(6,12),(7,10),(7,11),(7,12),(6,10).
- 5 bits, then cs high, then a full 0xAF -> frame_err once; display_on=1; no stray cmd_valid.
- 0x81 followed by a data byte 0x55 -> proto_err once; contrast unchanged at 0x7F; 0x55 written at 0/0.
- spi_rst pulsed low after a window change -> window 0..127/0..7, display_on=0, contrast=0x7F. Repeat with async reset asserted mid-byte -> identical state, no strobes.
